// File: rtl/cpu_sequencer.sv
// Control sequencer and instruction register for the instruction decoder.
// Sequences fetch/exec phases, holds EXEC2 for multi-cycle MUL, and handles STP halt and single-step pause.
module cpu_sequencer #(
  parameter int INSTR_WIDTH = 12,
  parameter int MUL_CYCLES  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   imem_valid,
  output logic [3:0]             state,
  output logic [3:0]             inst,
  output logic [INSTR_WIDTH-5:0] operand,
  output logic                   halted,
  output logic                   busy,
  output logic                   retired,
  output logic [15:0]            instr_cnt
);

  // Only the opcodes that change sequencing are named; every other code is a 1-phase instruction.
  localparam logic [3:0] OP_STP = 4'b0010;
  localparam logic [3:0] OP_LDA = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_LDR = 4'b1110;

  localparam int               CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_EXEC3,
    S_HALT,
    S_PAUSE
  } seq_state_t;

  seq_state_t             cur_q, nxt;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [CNT_W-1:0]       mul_cnt_q;
  logic                   run_q;

  logic       load_ir, load_mul, dec_mul;
  logic       is_stp, is_ext, is_mul;
  seq_state_t end_state;

  assign inst    = ir_q[INSTR_WIDTH-1 -: 4];
  assign operand = ir_q[INSTR_WIDTH-5:0];

  assign is_stp = (inst == OP_STP);
  assign is_mul = (inst == OP_MUL);
  assign is_ext = (inst == OP_LDA) || (inst == OP_LDR) || is_mul;

  // Where the sequencer goes once an instruction completes; run/step_mode only matter here.
  assign end_state = !run      ? S_IDLE  :
                     step_mode ? S_PAUSE :
                                 S_WAIT;

  // NOTE: every output of this block gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    nxt      = cur_q;
    retired  = 1'b0;
    load_ir  = 1'b0;
    load_mul = 1'b0;
    dec_mul  = 1'b0;
    state    = 4'b0000;
    halted   = 1'b0;
    busy     = 1'b0;

    case (cur_q)
      S_IDLE: begin
        if (run) nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (!run) begin
          nxt = S_IDLE;
        end else if (imem_valid) begin
          nxt     = S_FETCH;
          load_ir = 1'b1;
        end
      end
      S_FETCH: begin
        busy  = 1'b1;
        state = 4'b0001;
        nxt   = S_EXEC1;
      end
      S_EXEC1: begin
        busy  = 1'b1;
        state = 4'b0010;
        if (is_stp) begin
          retired = 1'b1;
          nxt     = S_HALT;
        end else if (is_ext) begin
          nxt      = S_EXEC2;
          load_mul = is_mul;
        end else begin
          retired = 1'b1;
          nxt     = end_state;
        end
      end
      S_EXEC2: begin
        busy  = 1'b1;
        state = 4'b0100;
        if (is_mul) begin
          if (mul_cnt_q == '0) nxt = S_EXEC3;
          else                 dec_mul = 1'b1;
        end else begin
          retired = 1'b1;
          nxt     = end_state;
        end
      end
      S_EXEC3: begin
        busy    = 1'b1;
        state   = 4'b1000;
        retired = 1'b1;
        nxt     = end_state;
      end
      S_HALT: begin
        halted = 1'b1;
        // Resume only on a fresh rising edge of run, so a run level held through STP does not restart.
        if (run && !run_q) nxt = S_WAIT;
      end
      S_PAUSE: begin
        if (!run)      nxt = S_IDLE;
        else if (step) nxt = S_WAIT;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q     <= S_IDLE;
      ir_q      <= '0;
      mul_cnt_q <= '0;
      run_q     <= 1'b0;
      instr_cnt <= '0;
    end else begin
      cur_q <= nxt;
      run_q <= run;
      if (load_ir) ir_q <= imem_data;
      if (load_mul)     mul_cnt_q <= MUL_LOAD;
      else if (dec_mul) mul_cnt_q <= mul_cnt_q - 1'b1;
      if (retired) instr_cnt <= instr_cnt + 16'd1;
    end
  end

  // The decoder relies on a one-hot (or idle) phase bus.
  a_state_onehot0 : assert property (@(posedge clk) $onehot0(state));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: phase sequences, MUL hold, memory stall,
// STP halt/resume, single-step, mid-instruction reset and retire-counter wrap.
module tb_cpu_sequencer;

  localparam int IW = 12;
  localparam int MC = 3;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          step_mode;
  logic          step;
  logic [IW-1:0] imem_data;
  logic          imem_valid;
  logic [3:0]    state;
  logic [3:0]    inst;
  logic [IW-5:0] operand;
  logic          halted;
  logic          busy;
  logic          retired;
  logic [15:0]   instr_cnt;

  int errors = 0;
  int checks = 0;

  cpu_sequencer #(.INSTR_WIDTH(IW), .MUL_CYCLES(MC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step_mode  (step_mode),
    .step       (step),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .state      (state),
    .inst       (inst),
    .operand    (operand),
    .halted     (halted),
    .busy       (busy),
    .retired    (retired),
    .instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the phase bus and retire pulse there.
  task automatic phase(input string tag, input logic [3:0] exp_state, input logic exp_ret);
    @(negedge clk);
    check({tag, ".state"}, 32'(state), 32'(exp_state));
    check({tag, ".retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    step_mode  = 1'b0;
    step       = 1'b0;
    imem_data  = '0;
    imem_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst.state",   32'(state), 32'h0);
    check("rst.halted",  32'(halted), 32'h0);
    check("rst.busy",    32'(busy), 32'h0);
    check("rst.retired", 32'(retired), 32'h0);
    check("rst.cnt",     32'(instr_cnt), 32'h0);
    check("rst.inst",    32'(inst), 32'h0);
    check("rst.operand", 32'(operand), 32'h0);

    // LDA 0x3A5: WAIT, FETCH, EXEC1, EXEC2 (retire)
    rst_n = 1'b1; run = 1'b1; imem_valid = 1'b1; imem_data = 12'h3A5;
    phase("lda.wait", 4'b0000, 1'b0);
    check("lda.wait.busy", 32'(busy), 32'h1);
    phase("lda.fetch", 4'b0001, 1'b0);
    check("lda.inst", 32'(inst), 32'h3);
    check("lda.operand", 32'(operand), 32'hA5);
    phase("lda.exec1", 4'b0010, 1'b0);
    phase("lda.exec2", 4'b0100, 1'b1);
    run = 1'b0; imem_valid = 1'b0;
    phase("lda.idle", 4'b0000, 1'b0);
    check("lda.idle.busy", 32'(busy), 32'h0);
    check("lda.cnt", 32'(instr_cnt), 32'h1);

    // MUL 0xD07: EXEC2 held 3 cycles, then EXEC3 retires
    run = 1'b1; imem_valid = 1'b1; imem_data = 12'hD07;
    phase("mul.wait", 4'b0000, 1'b0);
    phase("mul.fetch", 4'b0001, 1'b0);
    check("mul.inst", 32'(inst), 32'hD);
    check("mul.operand", 32'(operand), 32'h07);
    phase("mul.exec1", 4'b0010, 1'b0);
    for (int i = 0; i < MC; i++) phase($sformatf("mul.exec2_%0d", i), 4'b0100, 1'b0);
    phase("mul.exec3", 4'b1000, 1'b1);
    run = 1'b0; imem_valid = 1'b0;
    phase("mul.idle", 4'b0000, 1'b0);
    check("mul.cnt", 32'(instr_cnt), 32'h2);

    // Memory stall: 4 cycles of WAIT with changing data, IR untouched
    run = 1'b1; imem_valid = 1'b0; imem_data = 12'h5AA;
    for (int i = 0; i < 4; i++) begin
      phase($sformatf("stall_%0d", i), 4'b0000, 1'b0);
      check($sformatf("stall_%0d.busy", i), 32'(busy), 32'h1);
      check($sformatf("stall_%0d.inst", i), 32'(inst), 32'hD);
      check($sformatf("stall_%0d.operand", i), 32'(operand), 32'h07);
    end
    imem_data = 12'h1F0; imem_valid = 1'b1;
    phase("stall.fetch", 4'b0001, 1'b0);
    check("stall.inst", 32'(inst), 32'h1);
    check("stall.operand", 32'(operand), 32'hF0);
    phase("stall.exec1", 4'b0010, 1'b1);
    run = 1'b0; imem_valid = 1'b0;
    phase("stall.idle", 4'b0000, 1'b0);
    check("stall.cnt", 32'(instr_cnt), 32'h3);

    // STP 0x210: retire in EXEC1, HALT survives a held run level, resumes on run 0->1
    run = 1'b1; imem_valid = 1'b1; imem_data = 12'h210;
    phase("stp.wait", 4'b0000, 1'b0);
    phase("stp.fetch", 4'b0001, 1'b0);
    check("stp.inst", 32'(inst), 32'h2);
    phase("stp.exec1", 4'b0010, 1'b1);
    imem_valid = 1'b0; imem_data = 12'h3FF;
    for (int i = 0; i < 5; i++) begin
      phase($sformatf("halt_%0d", i), 4'b0000, 1'b0);
      check($sformatf("halt_%0d.halted", i), 32'(halted), 32'h1);
      check($sformatf("halt_%0d.busy", i), 32'(busy), 32'h0);
      check($sformatf("halt_%0d.inst", i), 32'(inst), 32'h2);
    end
    check("stp.cnt", 32'(instr_cnt), 32'h4);
    run = 1'b0;
    phase("halt.run_low", 4'b0000, 1'b0);
    check("halt.run_low.halted", 32'(halted), 32'h1);
    run = 1'b1;
    phase("halt.resume", 4'b0000, 1'b0);
    check("halt.resume.halted", 32'(halted), 32'h0);
    check("halt.resume.busy", 32'(busy), 32'h1);
    run = 1'b0;
    phase("halt.idle", 4'b0000, 1'b0);
    check("halt.idle.busy", 32'(busy), 32'h0);

    // Single-step: two JMPs, one instruction per step pulse
    step_mode = 1'b1; run = 1'b1; imem_valid = 1'b1; imem_data = 12'h1AB;
    phase("ss.wait", 4'b0000, 1'b0);
    phase("ss.fetch", 4'b0001, 1'b0);
    phase("ss.exec1", 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      phase($sformatf("ss.pause_%0d", i), 4'b0000, 1'b0);
      check($sformatf("ss.pause_%0d.busy", i), 32'(busy), 32'h0);
    end
    check("ss.cnt1", 32'(instr_cnt), 32'h5);
    step = 1'b1;
    phase("ss.step_wait", 4'b0000, 1'b0);
    check("ss.step_wait.busy", 32'(busy), 32'h1);
    step = 1'b0;
    phase("ss.fetch2", 4'b0001, 1'b0);
    phase("ss.exec1_2", 4'b0010, 1'b1);
    for (int i = 0; i < 2; i++) begin
      phase($sformatf("ss.pause2_%0d", i), 4'b0000, 1'b0);
      check($sformatf("ss.pause2_%0d.busy", i), 32'(busy), 32'h0);
    end
    check("ss.cnt2", 32'(instr_cnt), 32'h6);
    run = 1'b0; step = 1'b1;
    phase("ss.exit", 4'b0000, 1'b0);
    check("ss.exit.busy", 32'(busy), 32'h0);
    step = 1'b0; step_mode = 1'b0;

    // Reset during the 2nd MUL EXEC2 cycle
    run = 1'b1; imem_valid = 1'b1; imem_data = 12'hD07;
    phase("mrst.wait", 4'b0000, 1'b0);
    phase("mrst.fetch", 4'b0001, 1'b0);
    phase("mrst.exec1", 4'b0010, 1'b0);
    phase("mrst.exec2_0", 4'b0100, 1'b0);
    phase("mrst.exec2_1", 4'b0100, 1'b0);
    rst_n = 1'b0;
    phase("mrst.reset", 4'b0000, 1'b0);
    check("mrst.busy", 32'(busy), 32'h0);
    check("mrst.halted", 32'(halted), 32'h0);
    check("mrst.inst", 32'(inst), 32'h0);
    check("mrst.operand", 32'(operand), 32'h0);
    check("mrst.cnt", 32'(instr_cnt), 32'h0);
    run = 1'b0; imem_valid = 1'b0;
    phase("mrst.hold", 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Counter wrap: preset to 0xFFFE, two JMP retirements -> 0xFFFF then 0x0000
    force dut.instr_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.instr_cnt;
    run = 1'b1; imem_valid = 1'b1; imem_data = 12'h100;
    phase("wrap.wait", 4'b0000, 1'b0);
    phase("wrap.fetch", 4'b0001, 1'b0);
    phase("wrap.exec1", 4'b0010, 1'b1);
    phase("wrap.wait2", 4'b0000, 1'b0);
    check("wrap.cnt_ffff", 32'(instr_cnt), 32'hFFFF);
    phase("wrap.fetch2", 4'b0001, 1'b0);
    phase("wrap.exec1_2", 4'b0010, 1'b1);
    run = 1'b0; imem_valid = 1'b0;
    phase("wrap.idle", 4'b0000, 1'b0);
    check("wrap.cnt_zero", 32'(instr_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
